dragon_spawn_ctrl: RTL and testbench
====================================

# dragon_spawn_ctrl

Spawn scheduler for the enemy dragons. It owns N dragon slots and tracks each one's alive/cooldown status. Slots that are ready to respawn are served round-robin. The block enforces a minimum gap between spawns and a cap on simultaneous dragons, and supplies a randomized spawn position with each grant. It sits between the collision logic, which sends per-slot die requests, and the per-dragon movers, which load the position when their grant pulses.

## Interface
- N_SLOTS, 4, number of dragon slots (2..8)
- CD_TICKS, 100, respawn cooldown per slot, in clk_22 cycles
- GAP_TICKS, 20, minimum cycles between two consecutive grants
- MAX_ALIVE, 3, maximum simultaneously alive slots (1..N_SLOTS)
- clk_22  in  1  game tick clock
- rst  in  1  reset, asynchronous, active-low
- pause  in  1  freezes all state; no grants; die_req ignored
- start  in  1  single-cycle pulse: begin/restart game
- game_over  in  1  level: end game
- seed  in  10  LFSR seed, sampled only during reset
- die_req  in  N_SLOTS  per-slot death pulse (board exit or hit)
- spawn_grant  out  N_SLOTS  one-hot, one-cycle respawn pulse
- spawn_x  out  10  spawn x, valid in grant cycle
- spawn_y  out  10  spawn y, valid in grant cycle
- alive_mask  out  N_SLOTS  per-slot alive flag (drives show_valid)
- alive_cnt  out  4  popcount of alive_mask
- state  out  2  0 IDLE, 1 RUN, 2 OVER

## Operation
- FSM transitions:
  - IDLE --start--> RUN
  - RUN --game_over--> OVER
  - OVER --start--> RUN
  - In RUN, game_over has priority over start.
- Entering RUN:
  - all slots dead, every cd = 0
  - gap counter = 0, round-robin pointer = 0
- Entering OVER: alive_mask cleared and grants stop. In IDLE/OVER, die_req is ignored.
- Per-slot counter cd:
  - die_req[i] on an alive slot sets alive[i] = 0 and cd[i] = CD_TICKS.
  - die_req on a dead slot is ignored.
  - cd decrements by 1 each unpaused RUN cycle while nonzero.
  - A slot is ready when it is dead and cd == 0.
- Grant issued when all of the following hold:
  - state = RUN, pause = 0
  - gap == 0
  - alive_cnt < MAX_ALIVE
  - at least one slot is ready
- Grant selection and effects:
  - Winner is the first ready slot found scanning from the pointer upward, with wrap.
  - The winner's alive bit is set on the same edge.
  - pointer = (winner+1) mod N_SLOTS; gap = GAP_TICKS.
  - gap decrements each unpaused cycle while nonzero.
- Spawn position LFSR:
  - 10-bit Fibonacci LFSR, x^10+x^7+1.
  - Loaded with seed at reset; a seed of 0 is replaced by 10'h001.
  - Steps every unpaused cycle in every state.
  - spawn_x = (lfsr % 200) + 430.
  - spawn_y = (bitrev(lfsr) % 430) + 40.
  - Both are registered together with spawn_grant and hold their value between grants.
- Simultaneous die_req[j] and grant to slot i≠j: both apply on the same edge. The cap check uses the pre-edge alive_cnt.

## Timing
- Reset values:
  - state = IDLE
  - alive_mask = 0, alive_cnt = 0, spawn_grant = 0
  - spawn_x = 430, spawn_y = 40
  - all cd = 0, gap = 0, pointer = 0
- start accepted at edge s → state = RUN at s; first grant (slot 0) at edge s+1.
- die_req at edge k → cd reaches 0 at edge k+CD_TICKS. The earliest regrant of that slot is edge k+CD_TICKS+1, and each paused cycle adds one.
- Back-to-back grants are spaced exactly GAP_TICKS+1 cycles when no other constraint blocks.
- Asynchronous reset mid-game returns everything to reset values immediately; no grant pulse is emitted.

## Configuration
- DRAGON_SPAWN_RAMP_EN defined:
  - effective gap starts at GAP_TICKS
  - decreases by 1 after every 16 grants, to a minimum of 4
  - resets to GAP_TICKS on entering RUN
- Undefined: gap is fixed at GAP_TICKS and the grant counter is not built.

## Test plan
- Reset with seed = 0, then start: first grant spawn_grant = 4'b0001 at s+1; the LFSR runs from 10'h001. Then 4'b0010 at s+22 and 4'b0100 at s+43. No fourth grant occurs (alive_cnt = 3 = MAX_ALIVE).
- With 3 alive, pulse die_req = 4'b0010 at k: slot 3 is granted at k+1 (ready, cap freed, gap long expired). Slot 1 becomes eligible again only at k+101.
- Hold pause for 50 cycles while a slot is cooling down: cd, gap and LFSR freeze, no grant is issued, and a die_req pulsed during the pause has no effect. The regrant shifts by exactly 50 cycles.
- Assert game_over and start in the same RUN cycle: state goes to OVER and alive_mask = 0. A later start pulse re-enters RUN with the first grant to slot 0 one cycle later.
- Over many grants, check that every spawn_x lies in 430..629 and every spawn_y in 40..469. The LFSR never reaches 0.
- With DRAGON_SPAWN_RAMP_EN defined: grant spacing is 21 cycles for grants 1–16 and 20 cycles for grants 17–32, and never drops below 5.

Source files
------------

// File: rtl/dragon_spawn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dragon_spawn_ctrl_if
// Brief    : Slot-side bus of the dragon spawn scheduler: die requests in,
//            grants, spawn position and alive status out.
// Revision : 1.0  initial release
// ============================================================================
interface dragon_spawn_ctrl_if #(
    parameter int N_SLOTS = 4
);
    logic [N_SLOTS-1:0] die_req;
    logic [N_SLOTS-1:0] spawn_grant;
    logic [9:0]         spawn_x;
    logic [9:0]         spawn_y;
    logic [N_SLOTS-1:0] alive_mask;
    logic [3:0]         alive_cnt;

    // master: collision logic / movers; slave: the scheduler itself
    modport master (
        output die_req,
        input  spawn_grant,
        input  spawn_x,
        input  spawn_y,
        input  alive_mask,
        input  alive_cnt
    );

    modport slave (
        input  die_req,
        output spawn_grant,
        output spawn_x,
        output spawn_y,
        output alive_mask,
        output alive_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dragon_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dragon_spawn_ctrl
// Brief    : Round-robin respawn scheduler for N dragon slots with cooldown,
//            spawn gap, alive cap and LFSR spawn position.
//            Optional macro DRAGON_SPAWN_RAMP_EN shrinks the gap over time.
// Revision : 1.0  initial release
// ============================================================================
module dragon_spawn_ctrl #(
    parameter int N_SLOTS   = 4,
    parameter int CD_TICKS  = 100,
    parameter int GAP_TICKS = 20,
    parameter int MAX_ALIVE = 3
) (
    input  wire        clk_22,
    input  wire        rst,
    input  wire        pause,
    input  wire        start,
    input  wire        game_over,
    input  wire  [9:0] seed,
    output logic [1:0] state,
    dragon_spawn_ctrl_if.slave bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_OVER = 2'd2;

    localparam int c_PTR_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int c_CD_W  = (CD_TICKS  > 0) ? $clog2(CD_TICKS + 1)  : 1;
    localparam int c_GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [9:0] c_X_BASE = 10'd430;
    localparam logic [9:0] c_Y_BASE = 10'd40;

    logic [1:0]         r_state;
    logic [N_SLOTS-1:0] r_alive;
    logic [c_CD_W-1:0]  r_cd [N_SLOTS];
    logic [c_GAP_W-1:0] r_gap;
    logic [c_PTR_W-1:0] r_ptr;
    logic [9:0]         r_lfsr;
    logic [N_SLOTS-1:0] r_grant;
    logic [9:0]         r_spawn_x;
    logic [9:0]         r_spawn_y;

    logic [N_SLOTS-1:0] w_ready;
    logic [N_SLOTS-1:0] w_die;
    logic [N_SLOTS-1:0] w_grant_vec;
    logic [3:0]         w_alive_cnt;
    logic [c_PTR_W-1:0] w_win;
    logic               w_any_ready;
    logic               w_grant;
    logic               w_enter_run;
    logic [c_GAP_W-1:0] w_gap_load;
    logic [9:0]         w_lfsr_next;
    logic [9:0]         w_lfsr_rev;
    logic [9:0]         w_x;
    logic [9:0]         w_y;

    function automatic logic [c_PTR_W-1:0] f_wrap(input logic [c_PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_SLOTS) begin
            sum = sum - N_SLOTS;
        end
        return c_PTR_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Slot status
    // ------------------------------------------------------------------
    always_comb begin
        w_ready     = '0;
        w_alive_cnt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_ready[i]  = !r_alive[i] && (r_cd[i] == '0);
            w_alive_cnt = w_alive_cnt + 4'(r_alive[i]);
        end
    end

    // Only alive slots can die; requests on dead slots fall away here
    assign w_die = bus.die_req & r_alive;

    // Descending scan so the last hit is the first ready slot from the pointer
    always_comb begin
        w_any_ready = 1'b0;
        w_win       = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (w_ready[f_wrap(r_ptr, k)]) begin
                w_any_ready = 1'b1;
                w_win       = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_grant = (r_state == c_RUN) && !pause && !game_over &&
                     (r_gap == '0) && (w_alive_cnt < 4'(MAX_ALIVE)) && w_any_ready;

    assign w_enter_run = !pause && start && ((r_state == c_IDLE) || (r_state == c_OVER));

    always_comb begin
        w_grant_vec = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_grant_vec[i] = w_grant && (w_win == c_PTR_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Spawn position: x^10 + x^7 + 1 Fibonacci LFSR
    // ------------------------------------------------------------------
    assign w_lfsr_next = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};

    always_comb begin
        w_lfsr_rev = '0;
        for (int i = 0; i < 10; i++) begin
            w_lfsr_rev[i] = r_lfsr[9 - i];
        end
    end

    assign w_x = (r_lfsr % 10'd200) + c_X_BASE;
    assign w_y = (w_lfsr_rev % 10'd430) + c_Y_BASE;

    // ------------------------------------------------------------------
    // Gap reload value
    // ------------------------------------------------------------------
`ifdef DRAGON_SPAWN_RAMP_EN
    logic [c_GAP_W-1:0] r_gap_eff;
    logic [3:0]         r_grant_cnt;

    // The 16th grant of each batch already loads the shortened gap
    assign w_gap_load = ((r_grant_cnt == 4'd15) && (int'(r_gap_eff) > 4)) ?
                        (r_gap_eff - c_GAP_W'(1)) : r_gap_eff;

    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            r_gap_eff   <= c_GAP_W'(GAP_TICKS);
            r_grant_cnt <= '0;
        end else if (w_enter_run) begin
            r_gap_eff   <= c_GAP_W'(GAP_TICKS);
            r_grant_cnt <= '0;
        end else if (w_grant) begin
            r_gap_eff   <= w_gap_load;
            r_grant_cnt <= r_grant_cnt + 4'd1;
        end
    end
`else
    assign w_gap_load = c_GAP_W'(GAP_TICKS);
`endif

    // ------------------------------------------------------------------
    // Main state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_alive   <= '0;
            r_gap     <= '0;
            r_ptr     <= '0;
            r_lfsr    <= (seed == 10'd0) ? 10'h001 : seed;
            r_grant   <= '0;
            r_spawn_x <= c_X_BASE;
            r_spawn_y <= c_Y_BASE;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_cd[i] <= '0;
            end
        end else if (pause) begin
            r_grant <= '0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_grant <= w_grant_vec;

            case (r_state)
                c_IDLE, c_OVER: begin
                    if (w_enter_run) begin
                        r_state <= c_RUN;
                        r_alive <= '0;
                        for (int i = 0; i < N_SLOTS; i++) begin
                            r_cd[i] <= '0;
                        end
                    end
                end
                c_RUN: begin
                    if (game_over) begin
                        r_state <= c_OVER;
                        r_alive <= '0;
                    end else begin
                        r_alive <= (r_alive & ~w_die) | w_grant_vec;
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (w_die[i]) begin
                                r_cd[i] <= c_CD_W'(CD_TICKS);
                            end else if (r_cd[i] != '0) begin
                                r_cd[i] <= r_cd[i] - c_CD_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_alive <= '0;
                end
            endcase

            if (w_enter_run) begin
                r_gap <= '0;
                r_ptr <= '0;
            end else if (w_grant) begin
                r_gap <= w_gap_load;
                r_ptr <= f_wrap(w_win, 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_GAP_W'(1);
            end

            if (w_grant) begin
                r_spawn_x <= w_x;
                r_spawn_y <= w_y;
            end
        end
    end

    assign state           = r_state;
    assign bus.spawn_grant = r_grant;
    assign bus.spawn_x     = r_spawn_x;
    assign bus.spawn_y     = r_spawn_y;
    assign bus.alive_mask  = r_alive;
    assign bus.alive_cnt   = w_alive_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dragon_spawn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dragon_spawn_ctrl
// Brief    : Directed self-checking bench for dragon_spawn_ctrl (default build).
// Revision : 1.0  initial release
// ============================================================================
module tb_dragon_spawn_ctrl;

    logic       clk_22 = 1'b0;
    logic       rst;
    logic       pause;
    logic       start;
    logic       game_over;
    logic [9:0] seed;
    logic [1:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int         s, k, k2, p, q, at, ng;
    logic [3:0] v;

    logic [9:0] m_lfsr;
    logic [9:0] m_prev;

    dragon_spawn_ctrl_if #(.N_SLOTS(4)) bus ();

    dragon_spawn_ctrl #(
        .N_SLOTS   (4),
        .CD_TICKS  (100),
        .GAP_TICKS (20),
        .MAX_ALIVE (3)
    ) dut (
        .clk_22    (clk_22),
        .rst       (rst),
        .pause     (pause),
        .start     (start),
        .game_over (game_over),
        .seed      (seed),
        .state     (state),
        .bus       (bus)
    );

    always #5 clk_22 = ~clk_22;

    always @(posedge clk_22) cyc <= cyc + 1;

    // Reference position generator; m_prev is the value seen before the last edge
    always @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            m_lfsr <= (seed == 10'd0) ? 10'h001 : seed;
            m_prev <= (seed == 10'd0) ? 10'h001 : seed;
        end else if (!pause) begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        end
    end

    function automatic logic [9:0] bitrev10(input logic [9:0] a);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = a[9 - i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_spawn(input string tag);
        logic [9:0] ex;
        logic [9:0] ey;
        ex = (m_prev % 10'd200) + 10'd430;
        ey = (bitrev10(m_prev) % 10'd430) + 10'd40;
        check({tag, "_x"}, bus.spawn_x, ex);
        check({tag, "_y"}, bus.spawn_y, ey);
        check({tag, "_xrange"}, (bus.spawn_x >= 10'd430) && (bus.spawn_x <= 10'd629), 1);
        check({tag, "_yrange"}, (bus.spawn_y >= 10'd40) && (bus.spawn_y <= 10'd469), 1);
    endtask

    task automatic wait_grant(input int budget, output int at_cyc, output logic [3:0] vec);
        at_cyc = -1;
        vec    = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_22);
            if (bus.spawn_grant != '0) begin
                at_cyc = cyc;
                vec    = bus.spawn_grant;
                break;
            end
        end
    endtask

    task automatic expect_grant(input string tag, input int budget, input int exp_cyc,
                                input logic [3:0] exp_vec);
        int         a;
        logic [3:0] g;
        wait_grant(budget, a, g);
        check({tag, "_cyc"}, a, exp_cyc);
        check({tag, "_vec"}, g, exp_vec);
        if (a >= 0) check_spawn(tag);
    endtask

    task automatic pulse_die(input logic [3:0] d, output int edge_cyc);
        bus.die_req = d;
        @(negedge clk_22);
        bus.die_req = '0;
        edge_cyc = cyc;
    endtask

    task automatic pulse_start(output int edge_cyc);
        start = 1'b1;
        @(negedge clk_22);
        start = 1'b0;
        edge_cyc = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        pause       = 1'b0;
        start       = 1'b0;
        game_over   = 1'b0;
        seed        = 10'd0;
        bus.die_req = '0;
        repeat (2) @(negedge clk_22);
        check("rst_state", state, 0);
        check("rst_alive", bus.alive_mask, 0);
        check("rst_cnt",   bus.alive_cnt, 0);
        check("rst_grant", bus.spawn_grant, 0);
        check("rst_x",     bus.spawn_x, 430);
        check("rst_y",     bus.spawn_y, 40);

        rst = 1'b1;
        repeat (3) @(negedge clk_22);
        check("idle_hold", state, 0);

        // First round: three grants then the cap holds
        pulse_start(s);
        check("run_state", state, 1);
        check("run_nogrant", bus.spawn_grant, 0);
        expect_grant("g1", 5, s + 1, 4'b0001);
        check("g1_x_hand", bus.spawn_x, 446);
        check("g1_y_hand", bus.spawn_y, 72);
        check("g1_alive", bus.alive_mask, 4'b0001);
        expect_grant("g2", 30, s + 22, 4'b0010);
        expect_grant("g3", 30, s + 43, 4'b0100);
        check("cap_cnt", bus.alive_cnt, 3);
        wait_grant(60, at, v);
        check("cap_block", at, -1);

        // Freed cap goes to the next ready slot after the pointer
        pulse_die(4'b0010, k);
        expect_grant("refill", 5, k + 1, 4'b1000);
        check("refill_alive", bus.alive_mask, 4'b1101);
        repeat (3) @(negedge clk_22);
        pulse_die(4'b0001, k2);
        check("die0_alive", bus.alive_mask, 4'b1100);
        expect_grant("regrant1", 110, k + 101, 4'b0010);
        check("regrant1_cnt", bus.alive_cnt, 3);

        repeat (25) @(negedge clk_22);
        pulse_die(4'b0100, p);
        expect_grant("slot0", 5, p + 1, 4'b0001);
        check("slot0_alive", bus.alive_mask, 4'b1011);
        repeat (2) @(negedge clk_22);
        pulse_die(4'b1000, q);
        check("die3_alive", bus.alive_mask, 4'b0011);

        // 50 paused cycles with an ignored death in the middle
        repeat (5) @(negedge clk_22);
        pause = 1'b1;
        ng    = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_22);
            if (bus.spawn_grant != '0) ng++;
            if (i == 10) bus.die_req = 4'b0001;
            if (i == 11) bus.die_req = 4'b0000;
        end
        pause = 1'b0;
        check("pause_nogrant", ng, 0);
        check("pause_die_ignored", bus.alive_mask, 4'b0011);
        expect_grant("pause_shift", 120, p + 151, 4'b0100);

        // game_over wins over start
        game_over = 1'b1;
        start     = 1'b1;
        @(negedge clk_22);
        game_over = 1'b0;
        start     = 1'b0;
        check("over_state", state, 2);
        check("over_alive", bus.alive_mask, 0);
        check("over_grant", bus.spawn_grant, 0);
        repeat (5) @(negedge clk_22);
        check("over_hold", state, 2);
        check("over_cnt", bus.alive_cnt, 0);
        pulse_start(s);
        check("rerun_state", state, 1);
        expect_grant("rerun_g1", 5, s + 1, 4'b0001);

        // Repeated rounds to sweep spawn positions
        for (int r = 0; r < 8; r++) begin
            expect_grant("rng_a", 30, s + 22, 4'b0010);
            expect_grant("rng_b", 30, s + 43, 4'b0100);
            game_over = 1'b1;
            @(negedge clk_22);
            game_over = 1'b0;
            check("rng_over", state, 2);
            pulse_start(s);
            expect_grant("rng_c", 5, s + 1, 4'b0001);
        end

        // Asynchronous reset while a grant pulse is high
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", state, 0);
        check("arst_grant", bus.spawn_grant, 0);
        check("arst_alive", bus.alive_mask, 0);
        check("arst_x", bus.spawn_x, 430);
        check("arst_y", bus.spawn_y, 40);
        @(negedge clk_22);
        check("arst_hold_grant", bus.spawn_grant, 0);
        check("arst_hold_state", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
